// File: rtl/trimat_inv_ctrl.sv
// Stream front/back end for the 3x3 upper-triangular inverter: loads six elements,
// runs the inverter for a fixed number of cycles, then drains the six result elements.
module trimat_inv_ctrl #(
  parameter int DWIDTH      = 32,
  parameter int MATSIZE     = 3,
  parameter int INV_LATENCY = 10
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DWIDTH-1:0]                   in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DWIDTH-1:0]                   out_data,
  output logic                                out_last,
  output logic                                inv_vld,
  output logic                                inv_en,
  output logic [MATSIZE*MATSIZE*DWIDTH-1:0]   inv_mat_in,
  input  logic [MATSIZE*MATSIZE*DWIDTH-1:0]   inv_mat_out,
  output logic                                busy,
  output logic [1:0]                          dbg_state
);

  // Handshakes: a word moves on a rising edge where valid & ready are both high;
  // valid never depends on ready, and in_ready/out_valid come straight from state.
  localparam int CW = $clog2(INV_LATENCY + 1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              state_q;
  logic [2:0]          ld_idx_q;
  logic [2:0]          drn_idx_q;
  logic [CW-1:0]       run_cnt_q;
  logic [DWIDTH-1:0]   elem_q [6];
  logic [DWIDTH-1:0]   res_q  [6];
  logic [MATSIZE*MATSIZE*DWIDTH-1:0] mat_d;

  // Stream position -> flat matrix index (row-major upper triangle, MATSIZE fixed at 3).
  function automatic int slot_of(input int k);
    case (k)
      0:       slot_of = 0;
      1:       slot_of = 1;
      2:       slot_of = 2;
      3:       slot_of = 4;
      4:       slot_of = 5;
      default: slot_of = 8;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_LOAD;
      ld_idx_q  <= '0;
      drn_idx_q <= '0;
      run_cnt_q <= '0;
      for (int i = 0; i < 6; i++) begin
        elem_q[i] <= '0;
        res_q[i]  <= '0;
      end
    end else begin
      case (state_q)
        S_LOAD: begin
          if (in_valid) begin
            elem_q[ld_idx_q] <= in_data;
            if (ld_idx_q == 3'd5) begin
              ld_idx_q  <= '0;
              run_cnt_q <= CW'(1);
              state_q   <= S_RUN;
            end else begin
              ld_idx_q <= ld_idx_q + 3'd1;
            end
          end
        end
        S_RUN: begin
          if (run_cnt_q == CW'(INV_LATENCY)) begin
            for (int i = 0; i < 6; i++) begin
              res_q[i] <= inv_mat_out[slot_of(i)*DWIDTH +: DWIDTH];
            end
            run_cnt_q <= '0;
            state_q   <= S_DRAIN;
          end else begin
            run_cnt_q <= run_cnt_q + CW'(1);
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (drn_idx_q == 3'd5) begin
              drn_idx_q <= '0;
              state_q   <= S_LOAD;
            end else begin
              drn_idx_q <= drn_idx_q + 3'd1;
            end
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  // Lower-triangle slots stay zero; upper slots come from the load registers.
  always_comb begin
    mat_d = '0;
    for (int i = 0; i < 6; i++) begin
      mat_d[slot_of(i)*DWIDTH +: DWIDTH] = elem_q[i];
    end
  end

  assign inv_mat_in = mat_d;
  assign in_ready   = (state_q == S_LOAD);
  assign out_valid  = (state_q == S_DRAIN);
  assign busy       = (state_q != S_LOAD);
  assign inv_vld    = (state_q == S_RUN);
  assign inv_en     = (state_q == S_RUN);
  assign out_data   = res_q[drn_idx_q];
  assign out_last   = (state_q == S_DRAIN) && (drn_idx_q == 3'd5);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_trimat_inv_ctrl.sv
// Directed bench for trimat_inv_ctrl: drives matrices in, models the inverter as a
// fixed-latency lookup, and scores every drained element against a queue.
module tb_trimat_inv_ctrl;

  localparam int DW  = 32;
  localparam int MS  = 3;
  localparam int LAT = 10;
  localparam int FW  = MS*MS*DW;

  typedef logic [DW-1:0] word_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  word_t         in_data;
  logic          out_valid;
  logic          out_ready;
  word_t         out_data;
  logic          out_last;
  logic          inv_vld;
  logic          inv_en;
  logic [FW-1:0] inv_mat_in;
  logic [FW-1:0] inv_mat_out;
  logic          busy;
  logic [1:0]    dbg_state;

  trimat_inv_ctrl #(.DWIDTH(DW), .MATSIZE(MS), .INV_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .inv_vld(inv_vld), .inv_en(inv_en), .inv_mat_in(inv_mat_in), .inv_mat_out(inv_mat_out),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  logic [DW:0]   exp_q[$];
  logic [FW-1:0] mdl_q[$];
  logic [FW-1:0] cur_res = '0;
  int            mcnt = 0;
  int            e6_cyc = 0;
  int            last_xfer_cyc = 0;
  int            rdy_mode = 0;

  task automatic chk(input string name, input logic [FW:0] act, input logic [FW:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [FW-1:0] flat6(input word_t m[6], input word_t lower);
    logic [FW-1:0] f;
    f = {(MS*MS){lower}};
    f[0*DW +: DW] = m[0];
    f[1*DW +: DW] = m[1];
    f[2*DW +: DW] = m[2];
    f[4*DW +: DW] = m[3];
    f[5*DW +: DW] = m[4];
    f[8*DW +: DW] = m[5];
    return f;
  endfunction

  // ---------------- inverter model ----------------
  // Garbage until inv_vld has been high long enough, so an early capture is visible.
  always @(posedge clk) begin
    if (!inv_vld) mcnt <= 0;
    else          mcnt <= mcnt + 1;
  end
  assign inv_mat_out = (mcnt >= LAT-1) ? cur_res : {(MS*MS){32'hdeadbeef}};

  // ---------------- out_ready driver ----------------
  initial begin
    logic pat [9];
    int   p;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    p = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 1) begin
        out_ready = pat[p];
        p = (p + 1) % 9;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int          hi_cnt = 0;
  int          en_cnt = 0;
  int          lo_cnt = 0;
  bit          seen_run = 0;
  bit          stall = 0;
  bit          prev_ov = 0;
  logic [DW:0] held = '0;

  always @(negedge clk) begin
    if (rst) begin
      hi_cnt = 0; en_cnt = 0; lo_cnt = 0;
      seen_run = 0; stall = 0; prev_ov = 0;
    end else begin
      if (inv_vld) begin
        if (hi_cnt == 0) begin
          if (seen_run) chk("vld_gap_ge7", FW'(lo_cnt >= 7), 1);
          cur_res = (mdl_q.size() > 0) ? mdl_q.pop_front() : '0;
        end
        hi_cnt++;
        lo_cnt = 0;
      end else begin
        if (hi_cnt > 0) begin
          chk("vld_width", hi_cnt, LAT);
          chk("en_width", en_cnt, LAT);
          seen_run = 1;
        end
        hi_cnt = 0;
        en_cnt = 0;
        lo_cnt++;
      end
      if (inv_en) en_cnt++;

      if (out_valid && !prev_ov) chk("out_latency", cyc, e6_cyc + LAT);
      if (stall) chk("stall_hold", {out_valid, out_last, out_data}, {1'b1, held});

      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %0h expected no transfer (cycle %0d)", {out_last, out_data}, cyc);
        end else begin
          chk("out_elem", {out_last, out_data}, exp_q.pop_front());
        end
        if (out_last) last_xfer_cyc = cyc;
      end
      stall   = out_valid && !out_ready;
      held    = {out_last, out_data};
      prev_ov = out_valid;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic send_matrix(input word_t m[6], input int max_gap, input bit hold,
                             input word_t res[6], input bit expect_out, input bit follow);
    int n;
    int acc_cyc;
    mdl_q.push_back(flat6(res, 32'hbad00bad));
    for (int k = 0; k < 6; k++) begin
      int gap;
      gap = (max_gap > 0) ? (k % (max_gap + 1)) : 0;
      if (gap > 0) begin
        in_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = m[k];
      n = 0;
      @(negedge clk);
      while (!in_ready && n <= 300) begin
        n++;
        @(negedge clk);
      end
      if (!in_ready) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout: got 0 expected 1 (element %0d)", k);
      end
      acc_cyc = cyc;
      if (follow && k == 0) begin
        chk("b2b_wait", n, LAT + 6);
        chk("b2b_accept", acc_cyc, last_xfer_cyc + 1);
      end
      @(posedge clk);
      #1;
      if (k < 5) chk("vld_early", inv_vld, 0);
    end
    e6_cyc = cyc;
    if (!hold) in_valid = 1'b0;
    chk("mat_in", inv_mat_in, flat6(m, 32'h0));
    chk("vld_start", {inv_vld, inv_en, busy, in_ready}, 4'b1110);
    if (expect_out) begin
      for (int k = 0; k < 6; k++) exp_q.push_back({(k == 5), res[k]});
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() > 0 || busy) && t < 400) begin
      @(posedge clk);
      t++;
    end
    if (t >= 400) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vectors ----------------
  word_t id_m[6]  = '{32'h3f800000, 32'h0, 32'h0, 32'h3f800000, 32'h0, 32'h3f800000};
  word_t od_m[6]  = '{32'h3f800000, 32'h40000000, 32'h0, 32'h3f800000, 32'h0, 32'h3f800000};
  word_t od_r[6]  = '{32'h3f800000, 32'hc0000000, 32'h0, 32'h3f800000, 32'h0, 32'h3f800000};
  // [[1,2,3],[0,1,4],[0,0,1]] -> [[1,-2,5],[0,1,-4],[0,0,1]]
  word_t a_m[6]   = '{32'h3f800000, 32'h40000000, 32'h40400000, 32'h3f800000, 32'h40800000, 32'h3f800000};
  word_t a_r[6]   = '{32'h3f800000, 32'hc0000000, 32'h40a00000, 32'h3f800000, 32'hc0800000, 32'h3f800000};
  // [[2,1,0],[0,2,3],[0,0,4]] -> [[0.5,-0.25,0.1875],[0,0.5,-0.375],[0,0,0.25]]
  word_t g_m[6]   = '{32'h40000000, 32'h3f800000, 32'h0, 32'h40000000, 32'h40400000, 32'h40800000};
  word_t g_r[6]   = '{32'h3f000000, 32'hbe800000, 32'h3e400000, 32'h3f000000, 32'hbec00000, 32'h3e800000};

  initial begin
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 32'h12345678;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {in_ready, out_valid, out_last, inv_vld, inv_en, busy}, 6'b100000);
    chk("rst_out_data", out_data, 0);
    chk("rst_mat_in", inv_mat_in, 0);
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    // identity
    send_matrix(id_m, 0, 0, id_m, 1, 0);
    wait_idle();

    // off-diagonal
    send_matrix(od_m, 0, 0, od_r, 1, 0);
    wait_idle();

    // output backpressure
    rdy_mode = 1;
    send_matrix(a_m, 0, 0, a_r, 1, 0);
    wait_idle();
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // input gaps
    send_matrix(g_m, 3, 0, g_r, 1, 0);
    wait_idle();

    // reset in run cycle 4
    send_matrix(id_m, 0, 0, id_m, 0, 0);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("abort_drop", {inv_vld, inv_en, busy, in_ready, out_valid}, 5'b00010);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_data", out_data, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("abort_idle", {busy, out_valid, inv_vld}, 3'b000);
    send_matrix(id_m, 0, 0, id_m, 1, 0);
    wait_idle();

    // back-to-back with in_valid held
    send_matrix(od_m, 0, 1, od_r, 1, 0);
    send_matrix(a_m, 0, 0, a_r, 1, 1);
    wait_idle();

    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/trimat_inv_ctrl.md
# trimat_inv_ctrl

Streaming front/back end for the 3x3 upper-triangular matrix inverter. It accepts the six upper-triangle elements of a matrix over a valid/ready input stream and assembles the flat matrix bus. It sequences the inverter's `vld`/`en` for a fixed run length, captures the inverted matrix, and returns its six upper-triangle elements over a valid/ready output stream. It sits between the ESEKF covariance datapath and the inverter.

## Interface
- `DWIDTH`, 32: element width in bits (FP32 words; the block never interprets values).
- `MATSIZE`, 3: matrix dimension. Only 3 is supported.
- `INV_LATENCY`, 10: cycles that `inv_vld`/`inv_en` are held high per run. `inv_mat_out` is complete after this many cycles.

Ports:
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: input element valid.
- `in_ready`, output, 1: block accepts an input element.
- `in_data`, input, `DWIDTH`: input element.
- `out_valid`, output, 1: output element valid.
- `out_ready`, input, 1: downstream accepts the output element.
- `out_data`, output, `DWIDTH`: output element.
- `out_last`, output, 1: marks the 6th output element.
- `inv_vld`, output, 1: inverter run enable. Low clears the inverter's sequencing.
- `inv_en`, output, 1: inverter clock enable.
- `inv_mat_in`, output, `MATSIZE*MATSIZE*DWIDTH`: matrix to the inverter. Element (r,c) is at bits `(r*MATSIZE+c)*DWIDTH +: DWIDTH`.
- `inv_mat_out`, input, `MATSIZE*MATSIZE*DWIDTH`: inverted matrix, same layout.
- `busy`, output, 1: high in RUN or DRAIN.

## Operation
- Element order on both streams is row-major upper triangle: (0,0), (0,1), (0,2), (1,1), (1,2), (2,2). These map to flat indices 0, 1, 2, 4, 5, 8.
- States:
  - LOAD: reset state. `in_ready`=1. Each accepted element (`in_valid & in_ready` at an edge) is written to its slot, and the 3-bit load index increments. Gaps in `in_valid` are allowed. The 6th accept moves the state to RUN and clears the index.
  - RUN: `inv_vld`=`inv_en`=1. `inv_mat_in` is frozen. A run counter counts cycles from 1. On the edge ending cycle `INV_LATENCY`:
    - the six upper-triangle elements of `inv_mat_out` are captured into the result registers;
    - `inv_vld` and `inv_en` drop;
    - the state moves to DRAIN.
  - DRAIN: `out_valid`=1. `out_data` is the result element selected by the drain index. `out_last` = (index==5). Each `out_valid & out_ready` edge advances the index. The transfer with `out_last` returns the state to LOAD.
- `inv_mat_in` lower-triangle slots (3, 6, 7) are constant 0. Upper slots hold their last loaded value until overwritten.
- `in_ready` = (state==LOAD). `out_valid` = (state==DRAIN). `busy` = !LOAD. All three are decoded directly from registered state.
- `out_data` and `out_last` hold stable while `out_valid & !out_ready`.
- Results are not recomputed or checked; values pass through bit-exact.

## Timing
- Reset values (asynchronous, immediate on `rst`):
  - state LOAD;
  - `in_ready`=1, but no transfer is accepted while `rst` is high;
  - `out_valid`=0, `out_last`=0, `out_data`=0;
  - `inv_vld`=0, `inv_en`=0, `busy`=0;
  - `inv_mat_in`=0;
  - all indices and counters 0.
- Let E6 be the edge of the 6th input accept. `inv_vld` is high for cycles E6+1 through E6+`INV_LATENCY`. `out_valid` rises at edge E6+`INV_LATENCY`. With `INV_LATENCY`=10, that is 10 edges after E6.
- Drain is zero-bubble: one element per cycle while `out_ready`=1. Minimum drain is 6 cycles.
- `in_ready` rises on the edge of the `out_last` transfer. The next matrix can be accepted in that same following cycle.
- `inv_vld` is low for at least 6+1 cycles between runs, which guarantees the inverter restarts from count 0.
- Reset in any state aborts the operation:
  - a partial load is discarded;
  - `inv_vld` falls asynchronously;
  - undrained results are lost;
  - there is no spurious `out_valid` after release.
- `in_valid` during RUN or DRAIN is ignored: it is not accepted and not counted.

## Test plan
- Identity. Input 3f800000, 0, 0, 3f800000, 0, 3f800000 with a behavioural inverter model. Required: `inv_mat_in` slots 0/4/8 = 3f800000 and others 0; `inv_vld` high exactly 10 cycles; `out_valid` 10 edges after E6; output equals input; `out_last` only on the 6th element.
- Off-diagonal. Input 3f800000, 40000000, 0, 3f800000, 0, 3f800000. Required output: 3f800000, c0000000, 0, 3f800000, 0, 3f800000.
- Output backpressure. Drive `out_ready` with pattern 1,0,0,1,0,1,1,0,1. Required: `out_data`/`out_last` stable across stalls; exactly 6 transfers in order; no duplicates.
- Input gaps. Present elements with 0–3 idle cycles between them. Required: `inv_vld` stays 0 until after the 6th accept; slot 5 holds the 5th element; slots 3/6/7 are 0.
- Reset mid-RUN. Assert `rst` at run cycle 4. Required: `inv_vld`/`inv_en`/`busy` drop immediately; `out_valid` is never asserted; a following full identity transaction produces correct output.
- Back-to-back. Hold `in_valid`=1 with two matrices queued and `out_ready`=1. Required: `in_ready`=0 throughout RUN/DRAIN; the second matrix is accepted starting the cycle after the first `out_last`; both results are correct; `inv_vld` has a low gap of ≥7 cycles between runs.
